// File: rtl/bkm_xy_iter.sv
// rtl/bkm_xy_iter.sv - BKM E-mode X/Y iteration sequencer; E := E + (d*E)*2^-n per accepted digit pair.
// Build option BKM_XY_ITER_SAT_EN: saturate overflowing sums instead of wrapping modulo 2^W.
module bkm_xy_iter #(
    parameter int W       = 16,
    parameter int N_START = 1,
    parameter int N_ITER  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W-1:0]         x0,
    input  logic [W-1:0]         y0,
    input  logic                 d_valid,
    output logic                 d_ready,
    input  logic [1:0]           d_x,
    input  logic [1:0]           d_y,
    output logic [1:0]           mul_d_x,
    output logic [1:0]           mul_d_y,
    output logic [W-1:0]         mul_x,
    output logic [W-1:0]         mul_y,
    input  logic [W:0]           prod_x,
    input  logic [W:0]           prod_y,
    output logic [$clog2(W):0]   iter_n,
    output logic                 busy,
    output logic                 done,
    output logic [W-1:0]         x_out,
    output logic [W-1:0]         y_out,
    output logic                 ovf,
    output logic                 d_err
);

    localparam int NW = $clog2(W) + 1;
    localparam logic [NW-1:0] N_FIRST = NW'(N_START);
    localparam logic [NW-1:0] N_LAST  = NW'(N_ITER - 1);
    localparam logic [W-1:0]  S_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  S_MIN   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t              state, state_nx;
    logic [W-1:0]        x_r, y_r;
    logic [NW-1:0]       n_r;
    logic                ovf_r, err_r;
    logic                xfer, bad_d, ovf_x, ovf_y;
    logic signed [W+1:0] px_sh, py_sh, sum_x, sum_y;
    logic [W-1:0]        nx_x, nx_y;

    assign xfer  = d_valid && (state == S_ITER);
    assign bad_d = (d_x == 2'b10) || (d_y == 2'b10);

    // Illegal digit 10 is squashed to 0 so the multiplier returns a zero product.
    assign mul_d_x = (xfer && d_x != 2'b10) ? d_x : 2'b00;
    assign mul_d_y = (xfer && d_y != 2'b10) ? d_y : 2'b00;
    assign mul_x   = x_r;
    assign mul_y   = y_r;

    assign px_sh = $signed({prod_x[W], prod_x}) >>> n_r;
    assign py_sh = $signed({prod_y[W], prod_y}) >>> n_r;
    assign sum_x = $signed({{2{x_r[W-1]}}, x_r}) + px_sh;
    assign sum_y = $signed({{2{y_r[W-1]}}, y_r}) + py_sh;

    // In range iff the three top bits of the W+2 sum are all equal.
    assign ovf_x = !((sum_x[W+1:W-1] == 3'b000) || (sum_x[W+1:W-1] == 3'b111));
    assign ovf_y = !((sum_y[W+1:W-1] == 3'b000) || (sum_y[W+1:W-1] == 3'b111));

    always_comb begin
        nx_x = sum_x[W-1:0];
        nx_y = sum_y[W-1:0];
`ifdef BKM_XY_ITER_SAT_EN
        if (ovf_x) nx_x = sum_x[W+1] ? S_MIN : S_MAX;
        if (ovf_y) nx_y = sum_y[W+1] ? S_MIN : S_MAX;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        d_ready  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = S_ITER;
            S_ITER: begin
                busy    = 1'b1;
                d_ready = 1'b1;
                if (xfer && n_r == N_LAST) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r   <= '0;
            y_r   <= '0;
            n_r   <= '0;
            ovf_r <= 1'b0;
            err_r <= 1'b0;
        end else if (state == S_IDLE && start) begin
            x_r   <= x0;
            y_r   <= y0;
            n_r   <= N_FIRST;
            ovf_r <= 1'b0;
            err_r <= 1'b0;
        end else if (xfer) begin
            x_r   <= nx_x;
            y_r   <= nx_y;
            n_r   <= n_r + NW'(1);
            ovf_r <= ovf_r | ovf_x | ovf_y;
            err_r <= err_r | bad_d;
        end
    end

    assign x_out  = x_r;
    assign y_out  = y_r;
    assign iter_n = n_r;
    assign ovf    = ovf_r;
    assign d_err  = err_r;

endmodule

// File: tb/tb_bkm_xy_iter.sv
// tb/tb_bkm_xy_iter.sv - randomized self-checking bench for bkm_xy_iter against a behavioural model (W=8, N_START=1, N_ITER=4).
module tb_bkm_xy_iter;

    localparam int W  = 8;
    localparam int NS = 1;
    localparam int NI = 4;

    logic         clk = 1'b0;
    logic         rst, start, d_valid;
    logic [W-1:0] x0, y0;
    logic [1:0]   d_x, d_y;
    logic         d_ready, busy, done, ovf, d_err;
    logic [1:0]   mul_d_x, mul_d_y;
    logic [W-1:0] mul_x, mul_y, x_out, y_out;
    logic [W:0]   prod_x, prod_y;
    logic [3:0]   iter_n;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Behavioural model: e_st 0=idle, 1=iterating, 2=result pulse
    int e_st, e_x, e_y, e_n;
    bit e_ovf, e_err;

    always #5 clk = ~clk;

    bkm_xy_iter #(.W(W), .N_START(NS), .N_ITER(NI)) dut (
        .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0),
        .d_valid(d_valid), .d_ready(d_ready), .d_x(d_x), .d_y(d_y),
        .mul_d_x(mul_d_x), .mul_d_y(mul_d_y), .mul_x(mul_x), .mul_y(mul_y),
        .prod_x(prod_x), .prod_y(prod_y), .iter_n(iter_n), .busy(busy),
        .done(done), .x_out(x_out), .y_out(y_out), .ovf(ovf), .d_err(d_err)
    );

    function automatic int dval(logic [1:0] d);
        case (d)
            2'b01:   return 1;
            2'b11:   return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int sx9(int v);
        logic signed [8:0] t;
        t = v[8:0];
        return int'(t);
    endfunction

    function automatic int sx8(int v);
        logic signed [7:0] t;
        t = v[7:0];
        return int'(t);
    endfunction

    // Stand-in for the combinational bin2csd/multiply/csd2bin chain: complex d*E.
    assign prod_x = 9'(dval(mul_d_x) * int'($signed(mul_x)) - dval(mul_d_y) * int'($signed(mul_y)));
    assign prod_y = 9'(dval(mul_d_x) * int'($signed(mul_y)) + dval(mul_d_y) * int'($signed(mul_x)));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_st = 0; e_x = 0; e_y = 0; e_n = 0; e_ovf = 0; e_err = 0;
    endtask

    task automatic model_step(input bit s_rst, input bit s_start, input int s_x0, input int s_y0,
                              input bit s_dv, input logic [1:0] s_dx, input logic [1:0] s_dy);
        int a, b, pr, pi, sx, sy;
        if (s_rst) begin
            model_reset();
            return;
        end
        case (e_st)
            0: if (s_start) begin
                e_x = s_x0; e_y = s_y0; e_n = NS; e_ovf = 0; e_err = 0; e_st = 1;
            end
            1: if (s_dv) begin
                a  = dval(s_dx);
                b  = dval(s_dy);
                pr = sx9(a * e_x - b * e_y);
                pi = sx9(a * e_y + b * e_x);
                sx = e_x + (pr >>> e_n);
                sy = e_y + (pi >>> e_n);
                if (sx > 127 || sx < -128 || sy > 127 || sy < -128) e_ovf = 1;
`ifdef BKM_XY_ITER_SAT_EN
                e_x = (sx > 127) ? 127 : (sx < -128) ? -128 : sx;
                e_y = (sy > 127) ? 127 : (sy < -128) ? -128 : sy;
`else
                e_x = sx8(sx);
                e_y = sx8(sy);
`endif
                if (s_dx == 2'b10 || s_dy == 2'b10) e_err = 1;
                e_n++;
                if (e_n == NI) e_st = 2;
            end
            default: e_st = 0;
        endcase
    endtask

    // One clock: inputs present now are what the DUT sees at the coming edge.
    task automatic tick();
        bit         r = rst, s = start, v = d_valid;
        int         a = int'($signed(x0));
        int         b = int'($signed(y0));
        logic [1:0] p = d_x, q = d_y;
        @(posedge clk);
        #1;
        model_step(r, s, a, b, v, p, q);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [1:0] edx, edy;
            edx = (e_st == 1 && d_valid && d_x != 2'b10) ? d_x : 2'b00;
            edy = (e_st == 1 && d_valid && d_y != 2'b10) ? d_y : 2'b00;
            chk("busy",    busy,    e_st == 1);
            chk("d_ready", d_ready, e_st == 1);
            chk("done",    done,    e_st == 2);
            chk("x_out",   int'($signed(x_out)), e_x);
            chk("y_out",   int'($signed(y_out)), e_y);
            chk("mul_x",   int'($signed(mul_x)), e_x);
            chk("mul_y",   int'($signed(mul_y)), e_y);
            chk("iter_n",  iter_n,  e_n);
            chk("ovf",     ovf,     e_ovf);
            chk("d_err",   d_err,   e_err);
            chk("mul_d_x", mul_d_x, edx);
            chk("mul_d_y", mul_d_y, edy);
        end
    end

    function automatic logic [1:0] rand_digit();
        int v = $urandom_range(7);
        if (v < 3) return 2'b00;
        if (v < 5) return 2'b01;
        if (v < 7) return 2'b11;
        return 2'b10;
    endfunction

    // Full run: digit k sits in bits [2k+1:2k]; stall_pct is the chance of a d_valid=0 cycle.
    task automatic run(input int ax, input int ay, input logic [5:0] dxs, input logic [5:0] dys,
                       input int stall_pct);
        bit go;
        int guard;
        start = 1; x0 = ax[7:0]; y0 = ay[7:0]; d_valid = 0;
        tick();
        start = 0; x0 = 8'($urandom); y0 = 8'($urandom);
        for (int k = 0; k < 3; k++) begin
            guard = 0;
            do begin
                go = ($urandom_range(99) >= stall_pct) || (guard >= 20);
                d_valid = go;
                d_x = go ? dxs[2*k +: 2] : rand_digit();
                d_y = go ? dys[2*k +: 2] : rand_digit();
                start = !go && ($urandom_range(3) == 0);
                tick();
                guard++;
            end while (!go);
        end
        d_valid = 0; start = 0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1; start = 0; d_valid = 0; x0 = '0; y0 = '0; d_x = '0; d_y = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk_en = 1;
        tick();
        rst = 0;
        tick();

        run(50, -20, 6'b000000, 6'b000000, 0);
        chk("zero_x", int'($signed(x_out)), 50);
        chk("zero_y", int'($signed(y_out)), -20);
        chk("zero_ovf", ovf, 0);

        run(64, 0, 6'b001100, 6'b000001, 0);
        chk("cplx_x", int'($signed(x_out)), 48);
        chk("cplx_y", int'($signed(y_out)), 24);

        run(64, 0, 6'b010101, 6'b000000, 0);
`ifdef BKM_XY_ITER_SAT_EN
        chk("ovf_x", int'($signed(x_out)), 127);
`else
        chk("ovf_x", int'($signed(x_out)), -121);
`endif
        chk("ovf_flag", ovf, 1);

        run(-3, 0, 6'b001001, 6'b000000, 0);
        chk("neg_x", int'($signed(x_out)), -5);
        chk("neg_derr", d_err, 1);

        // Stall, ignored start, then asynchronous reset mid-run.
        start = 1; x0 = 8'd64; y0 = 8'd0;
        tick();
        start = 0; d_valid = 1; d_x = 2'b01; d_y = 2'b00;
        tick();
        d_valid = 0;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2); x0 = 8'd7; y0 = 8'd9;
            tick();
        end
        start = 0;
        chk("stall_n", iter_n, 2);
        chk("stall_x", int'($signed(x_out)), 96);
        d_valid = 1;
        tick();
        d_valid = 0;
        #2;
        rst = 1;
        model_reset();
        #1;
        chk("arst_x", x_out, 0);
        chk("arst_n", iter_n, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", d_ready, 0);
        tick();
        rst = 0;
        tick();
        tick();
        tick();

        // Back-to-back: a run leaving ovf and d_err set, then an immediate clean run.
        run(64, 0, 6'b010101, 6'b000010, 0);
        chk("b2b_a_ovf", ovf, 1);
        chk("b2b_a_derr", d_err, 1);
        run(10, 20, 6'b000000, 6'b000000, 0);
        chk("b2b_b_x", int'($signed(x_out)), 10);
        chk("b2b_b_ovf", ovf, 0);
        chk("b2b_b_derr", d_err, 0);

        for (int r = 0; r < 25; r++) begin
            logic [5:0] rx, ry;
            for (int k = 0; k < 3; k++) begin
                rx[2*k +: 2] = rand_digit();
                ry[2*k +: 2] = rand_digit();
            end
            run($urandom_range(255) - 128, $urandom_range(255) - 128, rx, ry, 35);
        end

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
